// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_cfg_pkg
// Purpose: Shared definitions for the SPI configuration master. Holds the
//          peripheral register map, the frame width and the controller
//          state encoding.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package spi_cfg_pkg;

  // Peripheral register map
  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;
  localparam logic [6:0] ADDR_MAX    = 7'h04;

  // Frame = {write flag, 7-bit address, 8-bit data}
  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // True when the address targets an implemented register
  function automatic logic addr_ok(input logic [6:0] addr);
    return (addr <= ADDR_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : spi_rr_arbiter
// Purpose: Two-way round-robin arbiter. When both requesters are valid the
//          one not granted last wins; a lone valid requester always wins.
//          The last-grant pointer only advances when a grant is consumed.
// Ports  : clk, rst_n      - clock, async active-low reset
//          valid_i[1:0]    - request valids
//          en_i            - grant is consumed this cycle if any is given
//          grant_o[1:0]    - one-hot grant (combinational)
//          last_grant_o    - requester granted most recently (1 = req1)
// Rev    : 1.0  initial release
// ============================================================================
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       last_grant_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0] && (!valid_i[1] || last_q)) begin
      grant_o[0] = 1'b1;
    end else if (valid_i[1]) begin
      grant_o[1] = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (en_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1];
    end
  end

  // Reset value points at req1 so req0 wins the first contested cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant_o = last_q;

endmodule
`default_nettype wire

// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : spi_cfg_master
// Purpose: Write-only SPI master for a small configuration peripheral.
//          Two requesters share the bus through a round-robin arbiter.
//          Each accepted write sends a 16-bit frame {1, addr, data} MSB
//          first, SPI mode 0 (sclk idle low, data changes on falling edge).
//          Writes to unimplemented addresses are dropped with an addr_err
//          pulse.
// Ports  : clk, rst_n                 - clock, async active-low reset
//          reqN_valid/addr/data/ready - requester N write handshake
//          ncs, sclk, copi            - registered SPI outputs
//          busy                       - controller not idle
//          addr_err                   - pulse: dropped out-of-range write
// Rev    : 1.0  initial release
// ============================================================================
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  output logic       busy,
  output logic       addr_err
);

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                ncs_q, ncs_d;
  logic                sclk_q, sclk_d;
  logic                copi_q, copi_d;
  logic                addr_err_q, addr_err_d;

  logic       idle;
  logic       accept;
  logic [1:0] grant;
  logic [6:0] sel_addr;
  logic [7:0] sel_data;
  logic       rr_last_grant_unused;

  assign idle = (state_q == IDLE);

  spi_rr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      ({req1_valid, req0_valid}),
    .en_i         (idle),
    .grant_o      (grant),
    .last_grant_o (rr_last_grant_unused)
  );

  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = idle & (grant != 2'b00);
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  // Output registers are loaded with the value they must show in the next
  // state, so pin changes line up exactly with state transitions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    ncs_d      = ncs_q;
    sclk_d     = sclk_q;
    copi_d     = copi_q;
    addr_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (addr_ok(sel_addr)) begin
            state_d = SETUP;
            cnt_d   = 8'd0;
            bit_d   = 5'd0;
            frame_d = {1'b1, sel_addr, sel_data};
            ncs_d   = 1'b0;
            sclk_d  = 1'b0;
            copi_d  = 1'b1;   // frame MSB is the write flag
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end

      SETUP: begin
        if (cnt_q == HP_LAST) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SHIFT: begin
        if (cnt_q == HP_LAST) begin
          cnt_d = 8'd0;
          if (sclk_q) begin
            // Falling edge: present next bit, or hand the final low
            // half-period over to HOLD after the last bit.
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            if (bit_q == BIT_LAST) begin
              state_d = HOLD;
            end else begin
              frame_d = {frame_q[FRAME_W-2:0], 1'b0};
              copi_d  = frame_q[FRAME_W-2];
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (cnt_q == HP_LAST) begin
          state_d = GAP;
          cnt_d   = 8'd0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        bit_d   = 5'd0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 5'd0;
      frame_q    <= '0;
      ncs_q      <= 1'b1;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      ncs_q      <= ncs_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign ncs      = ncs_q;
  assign sclk     = sclk_q;
  assign copi     = copi_q;
  assign addr_err = addr_err_q;
  assign busy     = !idle;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_cfg_master
// Purpose: Directed self-checking bench for spi_cfg_master. Two instances
//          (default timing and HALF_PERIOD=2/CS_GAP=1) are multiplexed onto
//          one set of stimulus/monitor signals and one SPI peripheral model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_cfg_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sel   = 1'b0;   // 0: default instance, 1: fast instance

  always #5 clk = ~clk;

  logic       r_v0 = 1'b0, r_v1 = 1'b0;
  logic [6:0] r_a0 = 7'd0, r_a1 = 7'd0;
  logic [7:0] r_d0 = 8'd0, r_d1 = 8'd0;

  logic a_rdy0, a_rdy1, a_ncs, a_sclk, a_copi, a_busy, a_err;
  logic b_rdy0, b_rdy1, b_ncs, b_sclk, b_copi, b_busy, b_err;
  logic m_rdy0, m_rdy1, m_ncs, m_sclk, m_copi, m_busy, m_err;

  spi_cfg_master #(.HALF_PERIOD(4), .CS_GAP(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r_v0 & ~sel), .req0_addr(r_a0), .req0_data(r_d0), .req0_ready(a_rdy0),
    .req1_valid(r_v1 & ~sel), .req1_addr(r_a1), .req1_data(r_d1), .req1_ready(a_rdy1),
    .ncs(a_ncs), .sclk(a_sclk), .copi(a_copi), .busy(a_busy), .addr_err(a_err)
  );

  spi_cfg_master #(.HALF_PERIOD(2), .CS_GAP(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r_v0 & sel), .req0_addr(r_a0), .req0_data(r_d0), .req0_ready(b_rdy0),
    .req1_valid(r_v1 & sel), .req1_addr(r_a1), .req1_data(r_d1), .req1_ready(b_rdy1),
    .ncs(b_ncs), .sclk(b_sclk), .copi(b_copi), .busy(b_busy), .addr_err(b_err)
  );

  assign m_rdy0 = sel ? b_rdy0 : a_rdy0;
  assign m_rdy1 = sel ? b_rdy1 : a_rdy1;
  assign m_ncs  = sel ? b_ncs  : a_ncs;
  assign m_sclk = sel ? b_sclk : a_sclk;
  assign m_copi = sel ? b_copi : a_copi;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_err  = sel ? b_err  : a_err;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI peripheral model: samples copi on sclk rise, commits only complete
  // 16-bit write frames when ncs returns high.
  logic [15:0] p_sh = 16'd0;
  int          p_cnt = 0;
  logic        p_ps = 1'b0, p_pn = 1'b1;
  logic [7:0]  p_regs [0:127] = '{default: 8'h00};

  always @(posedge clk) begin
    p_ps <= m_sclk;
    p_pn <= m_ncs;
    if (m_ncs) begin
      if (!p_pn && p_cnt == 16 && p_sh[15]) p_regs[p_sh[14:8]] <= p_sh[7:0];
      p_cnt <= 0;
    end else if (m_sclk && !p_ps) begin
      p_sh  <= {p_sh[14:0], m_copi};
      p_cnt <= p_cnt + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_ncs",  int'(m_ncs),  1);
    check_val("rst_sclk", int'(m_sclk), 0);
    check_val("rst_copi", int'(m_copi), 0);
    check_val("rst_busy", int'(m_busy), 0);
    check_val("rst_err",  int'(m_err),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a write; returns the acceptance cycle, #1 after the accepting edge.
  task automatic do_write(input int r, input logic [6:0] a, input logic [7:0] d, output int t);
    logic got;
    got = 1'b0;
    t   = -1;
    @(negedge clk);
    if (r == 0) begin r_v0 = 1'b1; r_a0 = a; r_d0 = d; end
    else        begin r_v1 = 1'b1; r_a1 = a; r_d1 = d; end
    for (int k = 0; k < 400 && !got; k++) begin
      #1;
      if ((r == 0 && m_rdy0) || (r == 1 && m_rdy1)) got = 1'b1;
      else @(negedge clk);
    end
    check_val("accept_seen", int'(got), 1);
    if (got) begin
      t = cyc;
      @(posedge clk);
      #1;
    end
    // Scrambled payload after acceptance must not disturb the frame
    r_v0 = 1'b0; r_v1 = 1'b0;
    r_a0 = ~a;   r_a1 = ~a;
    r_d0 = ~d;   r_d1 = ~d;
  endtask

  task automatic wait_frame(input logic [15:0] exp, input int t);
    int hp, gp, rel, ne, pos_bad, t_rise, t_idle, sclk_bad, copi_bad;
    logic [15:0] bits;
    logic ps, pn, pc, c_at_rise, n_at1;
    if (t < 0) return;
    hp = sel ? 2 : 4;
    gp = sel ? 1 : 8;
    ne = 0; pos_bad = 0; t_rise = -1; t_idle = -1; sclk_bad = 0; copi_bad = 0;
    bits = 16'd0; ps = 1'b0; pn = 1'b1; pc = 1'b0; c_at_rise = 1'b1; n_at1 = 1'b1;
    for (int i = 0; i < 40 * hp + gp + 8; i++) begin
      @(negedge clk);
      rel = cyc - t;
      if (rel == 1) n_at1 = m_ncs;
      if (m_sclk && !ps) begin
        if (ne < 16) bits[15-ne] = m_copi;
        if (rel != 1 + hp + 2 * hp * ne) pos_bad++;
        ne++;
      end
      if (m_ncs != pn && (m_sclk || ps)) sclk_bad++;
      if (!m_ncs && !pn && m_copi != pc && !(ps && !m_sclk)) copi_bad++;
      if (m_ncs && !pn && t_rise < 0) begin t_rise = rel; c_at_rise = m_copi; end
      if (!m_busy && t_idle < 0) t_idle = rel;
      ps = m_sclk; pn = m_ncs; pc = m_copi;
      if (t_idle >= 0) break;
    end
    check_val("ncs_low_T+1",   int'(n_at1), 0);
    check_val("sclk_edges",    ne, 16);
    check_val("edge_pos_bad",  pos_bad, 0);
    check_val("copi_bits",     int'(bits), int'(exp));
    check_val("ncs_rise_rel",  t_rise, 1 + 33 * hp);
    check_val("copi_at_rise",  int'(c_at_rise), 0);
    check_val("idle_rel",      t_idle, 1 + 33 * hp + gp);
    check_val("sclk_at_ncs",   sclk_bad, 0);
    check_val("copi_glitch",   copi_bad, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, nacc, c0, c1, both, ne;
    logic [3:0] ord;
    logic ps;
    logic [6:0]  tab_a [0:4] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
    logic [7:0]  tab_d [0:4] = '{8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'h80};
    logic [15:0] tab_f [0:4] = '{16'h80FF, 16'h810F, 16'h82F0, 16'h833C, 16'h8480};

    #1;
    do_reset();

    // Single write, default timing
    do_write(0, 7'h04, 8'hA5, t);
    wait_frame(16'h84A5, t);
    check_val("reg4_A5", int'(p_regs[4]), 'hA5);

    // Both requesters valid continuously: alternation from reset
    do_reset();
    @(negedge clk);
    r_v0 = 1'b1; r_a0 = 7'h00; r_d0 = 8'h11;
    r_v1 = 1'b1; r_a1 = 7'h01; r_d1 = 8'h22;
    nacc = 0; c0 = 0; c1 = 0; both = 0; ord = 4'd0;
    for (int k = 0; k < 800 && nacc < 4; k++) begin
      #1;
      if (m_rdy0 && m_rdy1) both++;
      if (m_rdy0) begin c0++; ord = {1'b0, ord[3:1]}; nacc++; end
      else if (m_rdy1) begin c1++; ord = {1'b1, ord[3:1]}; nacc++; end
      @(negedge clk);
    end
    r_v0 = 1'b0; r_v1 = 1'b0;
    for (int k = 0; k < 300 && m_busy; k++) @(negedge clk);
    check_val("rr_accepts", nacc, 4);
    check_val("rr_order",   int'(ord), 'b1010);
    check_val("rr_rdy0",    c0, 2);
    check_val("rr_rdy1",    c1, 2);
    check_val("rr_both",    both, 0);
    check_val("reg0_11",    int'(p_regs[0]), 'h11);
    check_val("reg1_22",    int'(p_regs[1]), 'h22);

    // Out-of-range address from req1
    do_write(1, 7'h10, 8'hFF, t);
    check_val("err_pulse",  int'(m_err),  1);
    check_val("err_ncs",    int'(m_ncs),  1);
    check_val("err_busy",   int'(m_busy), 0);
    @(posedge clk); #1;
    check_val("err_clear",  int'(m_err),  0);
    check_val("err_ncs2",   int'(m_ncs),  1);
    check_val("err_busy2",  int'(m_busy), 0);

    // Round-robin advanced to req1 by the rejected write; withdraw before accept
    @(negedge clk);
    r_v0 = 1'b1; r_v1 = 1'b1;
    #1;
    check_val("rr_after_err0", int'(m_rdy0), 1);
    check_val("rr_after_err1", int'(m_rdy1), 0);
    r_v0 = 1'b0;
    #1;
    check_val("lone_req1", int'(m_rdy1), 1);
    r_v1 = 1'b0;
    @(posedge clk); #1;
    check_val("withdraw_busy", int'(m_busy), 0);

    // First illegal address boundary
    do_write(0, 7'h05, 8'h00, t);
    check_val("err05_pulse", int'(m_err),  1);
    check_val("err05_busy",  int'(m_busy), 0);
    @(negedge clk);
    r_v0 = 1'b1; r_v1 = 1'b1;
    #1;
    check_val("rr_after05_1", int'(m_rdy1), 1);
    r_v0 = 1'b0; r_v1 = 1'b0;

    // Reset at the 8th rising sclk edge aborts the frame
    do_write(0, 7'h04, 8'h5A, t);
    ne = 0; ps = 1'b0;
    for (int k = 0; k < 300 && ne < 8; k++) begin
      @(negedge clk);
      if (m_sclk && !ps) ne++;
      ps = m_sclk;
    end
    check_val("abort_edge8", ne, 8);
    rst_n = 1'b0;
    #1;
    check_val("abort_ncs",  int'(m_ncs),  1);
    check_val("abort_sclk", int'(m_sclk), 0);
    check_val("abort_busy", int'(m_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_no_write", int'(p_regs[4]), 'hA5);
    do_write(0, 7'h04, 8'h5A, t);
    wait_frame(16'h845A, t);
    check_val("reg4_5A", int'(p_regs[4]), 'h5A);

    // Register sweep, alternating requesters
    for (int i = 0; i < 5; i++) begin
      do_write(i % 2, tab_a[i], tab_d[i], t);
      wait_frame(tab_f[i], t);
    end
    check_val("sweep_reg0", int'(p_regs[0]), 'hFF);
    check_val("sweep_reg1", int'(p_regs[1]), 'h0F);
    check_val("sweep_reg2", int'(p_regs[2]), 'hF0);
    check_val("sweep_reg3", int'(p_regs[3]), 'h3C);
    check_val("sweep_reg4", int'(p_regs[4]), 'h80);

    // Minimum timing instance
    sel = 1'b1;
    do_reset();
    do_write(1, 7'h03, 8'hC3, t);
    wait_frame(16'h83C3, t);
    check_val("fast_reg3", int'(p_regs[3]), 'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Parameter HALF_PERIOD, default 4, clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter CS_GAP, default 8, clk cycles ncs is held high between frames; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester N has a register write pending.
REQ-006 req0_addr / req1_addr  input  7  target register address.
REQ-007 req0_data / req1_data  input  8  write data.
REQ-008 req0_ready / req1_ready  output  1  write accepted this cycle when ready and valid are both high.
REQ-009 ncs  output  1  SPI chip select, active-low, registered.
REQ-010 sclk  output  1  SPI clock, idle low, registered.
REQ-011 copi  output  1  SPI serial data, MSB first, registered.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 addr_err  output  1  one-cycle pulse when an accepted request has addr > 7'h04.

Function
REQ-014 The block shall use states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 In IDLE, the arbiter shall grant one valid requester; reqN_ready shall be combinational: (state==IDLE) and grant==N.
REQ-016 Arbitration shall be 2-way round-robin: if both are valid, the requester not granted last wins; after reset req0 has priority; a single valid requester always wins.
REQ-017 On acceptance at cycle T with addr <= 7'h04, the block shall latch frame = {1'b1, addr, data} and enter SETUP at T+1.
REQ-018 On acceptance with addr > 7'h04, the block shall pulse addr_err at T+1, drive no frame, stay in IDLE and keep the round-robin update.
REQ-019 SETUP: ncs=0, sclk=0, copi=frame[15] from T+1, lasting HALF_PERIOD cycles.
REQ-020 SHIFT: 16 bits; each bit is sclk high for HALF_PERIOD cycles then low for HALF_PERIOD cycles; copi shall change only on the sclk falling edge (bit k+1 presented at the falling edge of bit k).
REQ-021 Bit k rising edge shall occur at cycle T+1+HALF_PERIOD+2*HALF_PERIOD*k, for k=0..15.
REQ-022 HOLD: after the 16th falling edge, ncs stays low HALF_PERIOD cycles; then ncs=1 and copi=0 at T+1+33*HALF_PERIOD.
REQ-023 GAP: ncs high for CS_GAP cycles; IDLE at T+1+33*HALF_PERIOD+CS_GAP, when ready may reassert.
REQ-024 Valid/addr/data changes outside the acceptance cycle shall not affect an in-flight frame.
REQ-025 A requester withdrawing valid before acceptance shall not be granted; no request is queued internally.
REQ-026 Exactly 16 rising sclk edges shall occur per ncs-low window; sclk shall be low whenever ncs changes.
REQ-027 Half-period and gap counters shall be 8 bits; the bit counter shall be 5 bits, terminating at 16 with no wrap.

Reset
REQ-028 Asserting rst_n low shall immediately force IDLE, ncs=1, sclk=0, copi=0, busy=0, addr_err=0, last-grant=req1 (so req0 wins next), and clear all counters.
REQ-029 Reset mid-frame shall abort the frame; the truncated frame (<16 edges) shall not be recovered or retried.

Structure
REQ-030 A shared package spi_cfg_pkg shall hold the register address constants (EN_OUT_7_0=0, EN_OUT_15_8=1, EN_PWM_7_0=2, EN_PWM_15_8=3, PWM_DUTY=4), ADDR_MAX=4, FRAME_W=16, and the state enumeration.
REQ-031 The round-robin grant logic shall be a sub-module spi_rr_arbiter (2 requesters, grant and last-grant outputs).

Verification
REQ-032 Reset, then req0 writes addr 04, data A5 with defaults -> ncs low T+1..T+132, 16 sclk pulses, copi bitstream 1000_0100_1010_0101, ncs high T+133, ready at T+141.
REQ-033 Both valid continuously, req0 {00,11}, req1 {01,22} -> frames alternate req0, req1, req0 …; each requester's ready pulses once per frame.
REQ-034 req1 addr 7'h10, data FF -> accepted, addr_err pulse at T+1, ncs stays high, busy stays 0.
REQ-035 rst_n low at the 8th rising sclk edge of a frame -> ncs=1, sclk=0 the same cycle; the next request yields a full, correct frame.
REQ-036 Loopback to the SPI peripheral (shared clk) writing 00:FF, 01:0F, 02:F0, 03:3C, 04:80 -> all five peripheral registers hold these values.
REQ-037 HALF_PERIOD=2, CS_GAP=1 -> correct frame timing per REQ-021/023; the peripheral captures the written value.
